// File: rtl/add_pipe_pkg.sv
// Shared types for the add_pipe block: operation encoding and the stage-2 result record.
package add_pipe_pkg;

  // Widest operand the block supports; the result record is sized for it.
  localparam int unsigned MaxWidth = 64;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Only the low WIDTH bits of result are meaningful; the upper bits stay zero.
  typedef struct packed {
    logic [MaxWidth-1:0] result;
    logic                carry;
    logic                ovf;
  } res_t;

endpackage

// File: rtl/add_pipe_slice.sv
// One valid/ready register slice: a single-entry pipeline register with full throughput.
// A slice holds its data while stalled.
// Reset clears the slice asynchronously.
// in_ready stays low until the first clock after reset release.
module add_pipe_slice #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
);

  logic             en_q;
  logic             valid_q;
  logic [Width-1:0] data_q;

  // Ready depends only on local state and downstream ready, never on in_valid.
  assign in_ready  = en_q & (~valid_q | out_ready);
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Slice register: load on accept, empty on drain, hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q    <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      en_q <= 1'b1;
      if (in_ready) begin
        valid_q <= in_valid;
        if (in_valid) begin
          data_q <= in_data;
        end
      end
    end
  end

endmodule

// File: rtl/add_pipe.sv
// Two-stage pipelined adder/subtractor with valid/ready handshakes on both sides.
// Stage 1 registers the operands and op; stage 2 registers result, carry and ovf.
// Optional macro ADD_PIPE_SAT_EN clamps the result on signed overflow.
// carry and ovf always report the true condition.
module add_pipe
  import add_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic             flag
);

  localparam int unsigned S1Width  = 2 * WIDTH + 1;
  localparam int unsigned ResWidth = $bits(res_t);

  logic [S1Width-1:0] s1_in;
  logic [S1Width-1:0] s1_out;
  logic               s1_valid;
  logic               s2_ready;

  logic [WIDTH-1:0]   s1_a;
  logic [WIDTH-1:0]   s1_b;
  op_e                s1_op;
  logic               is_sub;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH:0]     sum;
  res_t               res_d;
  res_t               res_q;
  logic               unused_res;

  assign s1_in = {op, a, b};

  add_pipe_slice #(
    .Width (S1Width)
  ) u_stage1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_out)
  );

  assign s1_op  = op_e'(s1_out[2*WIDTH]);
  assign s1_a   = s1_out[2*WIDTH-1:WIDTH];
  assign s1_b   = s1_out[WIDTH-1:0];
  assign is_sub = (s1_op == OP_SUB);

  // Subtract as a + ~b + 1 in WIDTH+1 bits; borrow is the inverted carry-out.
  always_comb begin
    b_eff = is_sub ? ~s1_b : s1_b;
    sum   = {1'b0, s1_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    res_d = '0;
    res_d.carry = sum[WIDTH] ^ is_sub;
    res_d.ovf   = (s1_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
    res_d.result[WIDTH-1:0] = sum[WIDTH-1:0];
`ifdef ADD_PIPE_SAT_EN
    // Overflow direction follows the sign of a: negative a can only overflow downward.
    if (res_d.ovf) begin
      res_d.result[WIDTH-1:0] = s1_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                              : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  add_pipe_slice #(
    .Width (ResWidth)
  ) u_stage2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (res_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (res_q)
  );

  assign result = res_q.result[WIDTH-1:0];
  assign carry  = res_q.carry;
  assign ovf    = res_q.ovf;
  assign flag   = res_q.carry | res_q.ovf;

  // Upper result bits are constant zero for WIDTH < MaxWidth.
  assign unused_res = ^res_q.result;

endmodule
